logic_function_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed-function two-input gate block.
- Applies a runtime-selected bitwise function to two W-bit operands.
- Produces a registered result plus status flags (zero, parity, ones-count).
- Uses valid/ready handshakes on input and output, with full backpressure and throughput of 1 beat/cycle.
- Sits between operand sources and result consumers in the lab datapath exercises.

---
 rtl/logic_function_pkg.sv | 39 +++
 rtl/popcount.sv | 18 +
 rtl/logic_function_pipe.sv | 107 ++++++++++
 tb/tb_logic_function_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_function_pkg.sv
// Shared types and the bitwise function table for the logic-function datapath blocks.
// apply_op works on OP_MAX_W-bit operands; callers zero-extend and truncate to their own W.
package logic_function_pkg;

    typedef enum logic [2:0] {
        AND    = 3'd0,
        OR     = 3'd1,
        XOR    = 3'd2,
        NAND   = 3'd3,
        NOR    = 3'd4,
        XNOR   = 3'd5,
        PASS_A = 3'd6,
        NOT_A  = 3'd7
    } logic_op_t;

    // Widest operand apply_op handles; bitwise lanes are independent, so truncation is exact.
    localparam int unsigned OP_MAX_W = 64;

    function automatic logic [OP_MAX_W-1:0] apply_op(
        input logic [OP_MAX_W-1:0] a,
        input logic [OP_MAX_W-1:0] b,
        input logic_op_t           op
    );
        logic [OP_MAX_W-1:0] y;
        case (op)
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            NAND:    y = ~(a & b);
            NOR:     y = ~(a | b);
            XNOR:    y = ~(a ^ b);
            PASS_A:  y = a;
            NOT_A:   y = ~a;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/popcount.sv
// Purely combinational ones-counter; count_o spans 0..W inclusive.
module popcount #(
    parameter  int W     = 8,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/logic_function_pipe.sv
// Two-stage valid/ready pipeline applying a runtime-selected bitwise function to two operands,
// with registered zero/parity/ones-count flags and full backpressure at 1 beat/cycle.
module logic_function_pipe
    import logic_function_pkg::*;
#(
    parameter  int W     = 8,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             n_reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic_op_t        in_op,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic_op_t        out_op,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_ones
);

    // Stage 1: captured operands
    logic             s1_valid_q;
    logic [W-1:0]     s1_a_q;
    logic [W-1:0]     s1_b_q;
    logic_op_t        s1_op_q;

    // Stage 2: result and flags, driven straight to the outputs
    logic             s2_valid_q;
    logic [W-1:0]     s2_y_q,      s2_y_d;
    logic_op_t        s2_op_q;
    logic             s2_zero_q,   s2_zero_d;
    logic             s2_parity_q, s2_parity_d;
    logic [CNT_W-1:0] s2_ones_q,   s2_ones_d;

    logic s1_adv;
    logic s2_adv;

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s2_y_d      = W'(apply_op(OP_MAX_W'(s1_a_q), OP_MAX_W'(s1_b_q), s1_op_q));
        s2_zero_d   = (s2_y_d == '0);
        s2_parity_d = ^s2_y_d;
    end

    popcount #(
        .W (W)
    ) u_popcount (
        .data_i  (s2_y_d),
        .count_o (s2_ones_d)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: data registers are reset as well so the outputs show defined values while in reset.
        if (!n_reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= AND;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q  <= in_a;
                s1_b_q  <= in_b;
                s1_op_q <= in_op;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s2_valid_q  <= 1'b0;
            s2_y_q      <= '0;
            s2_op_q     <= AND;
            s2_zero_q   <= 1'b1;
            s2_parity_q <= 1'b0;
            s2_ones_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            // Data only moves with a real beat; an empty stage 1 leaves stale data behind valid=0.
            if (s1_valid_q) begin
                s2_y_q      <= s2_y_d;
                s2_op_q     <= s1_op_q;
                s2_zero_q   <= s2_zero_d;
                s2_parity_q <= s2_parity_d;
                s2_ones_q   <= s2_ones_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_y      = s2_y_q;
    assign out_op     = s2_op_q;
    assign out_zero   = s2_zero_q;
    assign out_parity = s2_parity_q;
    assign out_ones   = s2_ones_q;

endmodule

// File: tb/tb_logic_function_pipe.sv
// Self-checking bench: truth-table reference model with an in-order expectation queue,
// plus directed vectors with literal expected values, backpressure, random traffic and resets.
module tb_logic_function_pipe;
    import logic_function_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic_op_t  in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic_op_t  out_op;
    logic       out_zero;
    logic       out_parity;
    logic [3:0] out_ones;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] op;
        logic       zero;
        logic       parity;
        logic [3:0] ones;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic_op_t  op;
        logic [7:0] y;
        logic       zero;
        logic       parity;
        logic [3:0] ones;
    } vec_t;

    res_t model_q[$];
    vec_t vecs[$];

    logic_function_pipe #(.W(8)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_ones   (out_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [3:0] tt [8];
        logic [3:0] row;
        res_t       r;
        int         n;
        tt  = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};
        row = tt[op];
        for (int i = 0; i < 8; i++) r.y[i] = row[{a[i], b[i]}];
        n        = $countones(r.y);
        r.op     = op;
        r.ones   = 4'(n);
        r.parity = (n % 2) == 1;
        r.zero   = (n == 0);
        return r;
    endfunction

    // Every cycle with out_valid high, the held beat must equal the oldest outstanding expectation.
    always @(negedge clk or negedge n_reset) begin
        res_t e;
        if (!n_reset) begin
            model_q.delete();
        end else begin
            if (out_valid) begin
                if (model_q.size() == 0) begin
                    check("spurious out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = model_q[0];
                    check("model y",      32'(out_y),      32'(e.y));
                    check("model op",     32'(out_op),     32'(e.op));
                    check("model zero",   32'(out_zero),   32'(e.zero));
                    check("model parity", 32'(out_parity), 32'(e.parity));
                    check("model ones",   32'(out_ones),   32'(e.ones));
                    if (out_ready) void'(model_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_q.push_back(model(in_a, in_b, in_op));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic_op_t op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    // Streams vecs back to back with out_ready high; beat c is held on the outputs in cycle c+2.
    task automatic run_vecs(input string tag);
        out_ready = 1'b1;
        for (int c = 0; c < vecs.size() + 2; c++) begin
            if (c < vecs.size()) drive(1'b1, vecs[c].a, vecs[c].b, vecs[c].op);
            else                 drive(1'b0, 8'hxx, 8'hxx, AND);
            @(negedge clk);
            if (c < vecs.size()) check({tag, " in_ready"}, 32'(in_ready), 32'd1);
            if (c >= 2) begin
                check({tag, " out_valid"},  32'(out_valid),  32'd1);
                check({tag, " out_y"},      32'(out_y),      32'(vecs[c-2].y));
                check({tag, " out_op"},     32'(out_op),     32'(vecs[c-2].op));
                check({tag, " out_zero"},   32'(out_zero),   32'(vecs[c-2].zero));
                check({tag, " out_parity"}, 32'(out_parity), 32'(vecs[c-2].parity));
                check({tag, " out_ones"},   32'(out_ones),   32'(vecs[c-2].ones));
            end else begin
                check({tag, " early out_valid"}, 32'(out_valid), 32'd0);
            end
            step();
        end
        @(negedge clk);
        check({tag, " drained out_valid"}, 32'(out_valid), 32'd0);
        step();
        vecs.delete();
    endtask

    task automatic pulse_reset(input string tag);
        in_valid = 1'b0;
        @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        check({tag, " out_valid drops in reset"}, 32'(out_valid), 32'd0);
        check({tag, " out_y in reset"},           32'(out_y),      32'd0);
        check({tag, " out_op in reset"},          32'(out_op),     32'(AND));
        check({tag, " out_zero in reset"},        32'(out_zero),   32'd1);
        check({tag, " out_parity in reset"},      32'(out_parity), 32'd0);
        check({tag, " out_ones in reset"},        32'(out_ones),   32'd0);
        repeat (2) @(posedge clk);
        #3 n_reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] y2 [8];
        bit   [12:0] rdy4, ir4, v4;
        logic [7:0] y4 [13];
        int         idx, accepted, cyc;
        logic       acc;

        n_reset   = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, AND);

        // 1: reset, then a held beat, then a mid-cycle reset that must drop out_valid at once
        repeat (2) @(posedge clk);
        #3 n_reset = 1'b1;
        step();
        drive(1'b1, 8'h12, 8'h34, OR);
        step();
        drive(1'b0, 8'hxx, 8'hxx, AND);
        step();
        @(negedge clk);
        check("t1 out_valid before reset", 32'(out_valid), 32'd1);
        pulse_reset("t1");
        @(posedge clk);
        @(negedge clk);
        check("t1 in_ready after release",  32'(in_ready),  32'd1);
        check("t1 out_valid after release", 32'(out_valid), 32'd0);
        check("t1 out_zero after release",  32'(out_zero),  32'd1);
        step();

        // 2: every op on A5/3C, back to back
        y2 = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5, 8'h5A};
        for (int k = 0; k < 8; k++) begin
            vecs.push_back('{8'hA5, 8'h3C, logic_op_t'(k), y2[k], (y2[k] == 8'h00),
                             ^y2[k], 4'($countones(y2[k]))});
        end
        run_vecs("t2");

        // 3: flag corner cases
        vecs.push_back('{8'hFF, 8'hFF, XOR, 8'h00, 1'b1, 1'b0, 4'd0});
        vecs.push_back('{8'hFF, 8'h00, OR,  8'hFF, 1'b0, 1'b0, 4'd8});
        vecs.push_back('{8'h01, 8'h01, AND, 8'h01, 1'b0, 1'b1, 4'd1});
        run_vecs("t3");

        // 4: backpressure over cycles 2..6 while five XOR beats stream in
        rdy4 = 13'b1_1111_1000_0011;
        ir4  = 13'b1_1111_1000_0011;
        v4   = 13'b0_1111_1111_1100;
        y4   = '{8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
                 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h00};
        idx = 0;
        for (int c = 0; c < 13; c++) begin
            out_ready = rdy4[c];
            if (idx < 5) drive(1'b1, 8'(idx), 8'h0F, XOR);
            else         drive(1'b0, 8'hxx, 8'hxx, AND);
            @(negedge clk);
            acc = in_valid && in_ready;
            check("t4 in_ready",  32'(in_ready),  32'(ir4[c]));
            check("t4 out_valid", 32'(out_valid), 32'(v4[c]));
            if (v4[c]) check("t4 out_y", 32'(out_y), 32'(y4[c]));
            step();
            if (acc) idx++;
        end
        check("t4 beats accepted", 32'(idx), 32'd5);

        // 5: random in_valid / out_ready traffic against the model queue
        accepted = 0;
        cyc      = 0;
        while (accepted < 1000 && cyc < 20000) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  logic_op_t'($urandom_range(0, 7)));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            step();
            cyc++;
        end
        check("t5 beats accepted", 32'(accepted), 32'd1000);
        drive(1'b0, 8'hxx, 8'hxx, AND);
        out_ready = 1'b1;
        cyc = 0;
        while (model_q.size() > 0 && cyc < 50) begin
            step();
            cyc++;
        end
        check("t5 queue drained", 32'(model_q.size()), 32'd0);
        @(negedge clk);
        check("t5 out_valid idle", 32'(out_valid), 32'd0);
        step();

        // 6: reset with both stages full, then a fresh beat
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, XOR);
        step();
        drive(1'b1, 8'h33, 8'h44, NOR);
        step();
        drive(1'b0, 8'hxx, 8'hxx, AND);
        @(negedge clk);
        check("t6 stages full in_ready", 32'(in_ready),  32'd0);
        check("t6 out_valid before",     32'(out_valid), 32'd1);
        pulse_reset("t6");
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6 no stale out_valid", 32'(out_valid), 32'd0);
        end
        step();
        vecs.push_back('{8'hF0, 8'h3C, AND, 8'h30, 1'b0, 1'b0, 4'd2});
        run_vecs("t6");
        check("t6 queue empty", 32'(model_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
